pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, computes the next PC from PCSrc and runs the
// instruction-fetch handshake to instruction memory.
// Each fetched instruction is presented for exactly one EXEC residency.
// Stall extends that residency; PCSrc is sampled on the cycle Stall is low.
// Optional feature macro: PC_SEQ_PERF_EN enables the RetireCnt/TakenCnt
// performance counters. When it is undefined, both outputs are tied to zero.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] Imm16,
  input  logic [25:0] Target26,
  input  logic [31:0] RsVal,
  input  logic        Stall,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Err,
  output logic [31:0] RetireCnt,
  output logic [31:0] TakenCnt
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_instr;
  logic        w_instr_load;
  logic        r_err;
  logic        w_err_next;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_jr_tgt;
  logic [31:0] w_npc;
  logic        w_misalign;
  logic        w_trap;

  // Next-PC candidates; all arithmetic wraps modulo 2^32.
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_branch_tgt = w_pc_plus4 + {{14{Imm16[15]}}, Imm16, 2'b00};
  assign w_jump_tgt   = {w_pc_plus4[31:28], Target26, 2'b00};
  // Low bits are cleared: this is only used when the target is aligned
  // or when misaligned targets are silently realigned.
  assign w_jr_tgt     = {RsVal[31:2], 2'b00};
  assign w_misalign   = (PCSrc == 2'b11) && (RsVal[1:0] != 2'b00);
  assign w_trap       = w_misalign && ERR_ON_MISALIGN;

  // Next-PC select from PCSrc.
  always_comb begin
    w_npc = w_pc_plus4;
    case (PCSrc)
      2'b00:   w_npc = w_pc_plus4;
      2'b01:   w_npc = w_branch_tgt;
      2'b10:   w_npc = w_jump_tgt;
      default: w_npc = w_jr_tgt;
    endcase
  end

  // FSM next-state, PC update and trap decision.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_err_next   = r_err;
    w_instr_load = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (ImemReady) begin
          w_instr_load = 1'b1;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!Stall) begin
          if (w_trap) begin
            w_err_next   = 1'b1;
            w_state_next = ST_TRAP;
          end else begin
            w_pc_next    = w_npc;
            w_state_next = ST_FETCH;
          end
        end
      end
      ST_TRAP: begin
        w_state_next = ST_TRAP;
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
  end

  // State, PC, instruction latch and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_err   <= w_err_next;
      if (w_instr_load) begin
        r_instr <= ImemData;
      end
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [31:0] r_retire_cnt;
  logic [31:0] r_taken_cnt;
  logic        w_retire;

  assign w_retire = (r_state == ST_EXEC) && !Stall && !w_trap;

  // Performance counters: retired instructions and non-sequential exits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt <= 32'h0;
      r_taken_cnt  <= 32'h0;
    end else if (w_retire) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
      if (PCSrc != 2'b00) begin
        r_taken_cnt <= r_taken_cnt + 32'd1;
      end
    end
  end

  assign RetireCnt = r_retire_cnt;
  assign TakenCnt  = r_taken_cnt;
`else
  assign RetireCnt = 32'h0;
  assign TakenCnt  = 32'h0;
`endif

  // Request is suppressed during the reset cycle itself so memory never
  // sees a fetch for a PC that is about to be overwritten.
  assign ImemReq    = (r_state == ST_FETCH) && !rst;
  assign ImemAddr   = r_pc;
  assign InstrValid = (r_state == ST_EXEC);
  assign Instr      = r_instr;
  assign PC         = r_pc;
  assign PCPlus4    = w_pc_plus4;
  assign Err        = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table-driven instruction vectors with
// an address/instruction scoreboard, plus hand-written stall, trap and reset
// sequences. A second instance runs with misaligned jr realignment.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PCSrc;
  logic [15:0] Imm16;
  logic [25:0] Target26;
  logic [31:0] RsVal;
  logic        Stall;
  logic        ImemReady;
  logic [31:0] ImemData;

  logic        a_ImemReq, a_InstrValid, a_Err;
  logic [31:0] a_ImemAddr, a_Instr, a_PC, a_PCPlus4, a_RetireCnt, a_TakenCnt;
  logic        b_ImemReq, b_InstrValid, b_Err;
  logic [31:0] b_ImemAddr, b_Instr, b_PC, b_PCPlus4, b_RetireCnt, b_TakenCnt;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .ERR_ON_MISALIGN(1'b1)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .Imm16(Imm16), .Target26(Target26),
    .RsVal(RsVal), .Stall(Stall), .ImemReady(ImemReady), .ImemData(ImemData),
    .ImemReq(a_ImemReq), .ImemAddr(a_ImemAddr), .Instr(a_Instr),
    .InstrValid(a_InstrValid), .PC(a_PC), .PCPlus4(a_PCPlus4), .Err(a_Err),
    .RetireCnt(a_RetireCnt), .TakenCnt(a_TakenCnt)
  );

  pc_sequencer #(.RESET_PC(32'h0000_0000), .ERR_ON_MISALIGN(1'b0)) dut_nomis (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .Imm16(Imm16), .Target26(Target26),
    .RsVal(RsVal), .Stall(Stall), .ImemReady(ImemReady), .ImemData(ImemData),
    .ImemReq(b_ImemReq), .ImemAddr(b_ImemAddr), .Instr(b_Instr),
    .InstrValid(b_InstrValid), .PC(b_PC), .PCPlus4(b_PCPlus4), .Err(b_Err),
    .RetireCnt(b_RetireCnt), .TakenCnt(b_TakenCnt)
  );

`ifdef PC_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [1:0]  src;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] rs;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs[13];
  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_retire = 0;
  int          exp_taken = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_retire"}, a_RetireCnt, PERF ? 32'(exp_retire) : 32'h0);
    chk({tag, "_taken"},  a_TakenCnt,  PERF ? 32'(exp_taken)  : 32'h0);
  endtask

  // Fetch one instruction (waiting a bounded number of cycles for the
  // request), then execute it with the given next-PC controls.
  task automatic do_instr(input int idx, input vec_t v);
    int          cnt;
    logic [31:0] exp_addr;
    logic [31:0] data;
    cnt = 0;
    while (!a_ImemReq && cnt < 8) begin
      step();
      cnt++;
    end
    chk("fetch_req", {31'h0, a_ImemReq}, 32'h1);
    exp_addr = addr_q.pop_front();
    chk("fetch_addr", a_ImemAddr, exp_addr);
    chk("fetch_noval", {31'h0, a_InstrValid}, 32'h0);
    data      = $urandom;
    ImemReady = 1'b1;
    ImemData  = data;
    instr_q.push_back(data);
    step();
    ImemReady = 1'b0;
    ImemData  = $urandom;
    chk("exec_valid", {31'h0, a_InstrValid}, 32'h1);
    chk("exec_instr", a_Instr, instr_q.pop_front());
    chk("exec_pcplus4", a_PCPlus4, exp_addr + 32'd4);
    PCSrc    = v.src;
    Imm16    = v.imm;
    Target26 = v.tgt;
    RsVal    = v.rs;
    Stall    = 1'b0;
    addr_q.push_back(v.exp_pc);
    exp_retire++;
    if (v.src != 2'b00) exp_taken++;
    step();
    PCSrc = 2'($urandom);
    RsVal = $urandom;
    $display("instr %0d: addr=%h src=%0d next_pc=%h (required %h)",
             idx, exp_addr, v.src, a_PC, v.exp_pc);
    chk("next_pc", a_PC, v.exp_pc);
    chk("next_pc_nomis", b_PC, v.exp_pc);
  endtask

  initial begin
    logic [31:0] data;
    vec_t        v;

    vecs[0]  = '{2'b00, 16'h0000, 26'h0,  32'h0,         32'h0000_0004};
    vecs[1]  = '{2'b00, 16'h0000, 26'h0,  32'h0,         32'h0000_0008};
    vecs[2]  = '{2'b00, 16'h0000, 26'h0,  32'h0,         32'h0000_000C};
    vecs[3]  = '{2'b11, 16'h0000, 26'h0,  32'h0000_0100, 32'h0000_0100};
    vecs[4]  = '{2'b01, 16'hFFFE, 26'h0,  32'h0,         32'h0000_00FC};
    vecs[5]  = '{2'b11, 16'h0000, 26'h0,  32'h0000_0100, 32'h0000_0100};
    vecs[6]  = '{2'b01, 16'h0003, 26'h0,  32'h0,         32'h0000_0110};
    vecs[7]  = '{2'b11, 16'h0000, 26'h0,  32'h9000_0010, 32'h9000_0010};
    vecs[8]  = '{2'b10, 16'h0000, 26'h40, 32'h0,         32'h9000_0100};
    vecs[9]  = '{2'b11, 16'h0000, 26'h0,  32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[10] = '{2'b00, 16'h0000, 26'h0,  32'h0,         32'h0000_0000};
    vecs[11] = '{2'b01, 16'h8000, 26'h0,  32'h0,         32'hFFFE_0004};
    vecs[12] = '{2'b11, 16'h0000, 26'h0,  32'h0000_2000, 32'h0000_2000};

    rst = 1'b1; PCSrc = 2'b00; Imm16 = 16'h0; Target26 = 26'h0; RsVal = 32'h0;
    Stall = 1'b0; ImemReady = 1'b0; ImemData = 32'h0;
    step();
    chk("rst_req_low", {31'h0, a_ImemReq}, 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_pc", a_PC, 32'h0);
    chk("rst_req", {31'h0, a_ImemReq}, 32'h1);
    chk("rst_instr", a_Instr, 32'h0);
    chk("rst_err", {31'h0, a_Err}, 32'h0);
    chk("rst_valid", {31'h0, a_InstrValid}, 32'h0);
    chk_counters("rst");
    addr_q.push_back(32'h0);

    // Table-driven instruction stream.
    for (int i = 0; i < 13; i++) begin
      do_instr(i, vecs[i]);
      if (i == 2) chk_counters("seq3");
    end
    chk_counters("table");

    // Ready gap of 3 cycles, then Stall for 2 cycles with PCSrc toggling.
    chk("gap_addr0", a_ImemAddr, addr_q.pop_front());
    PCSrc = 2'b11; RsVal = 32'h0000_5000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_addr", a_ImemAddr, 32'h0000_2000);
      chk("gap_req", {31'h0, a_ImemReq}, 32'h1);
    end
    data = $urandom;
    ImemReady = 1'b1; ImemData = data;
    step();
    ImemData = ~data;
    Stall = 1'b1; PCSrc = 2'b11; RsVal = 32'h0000_3000;
    step();
    chk("stall1_pc", a_PC, 32'h0000_2000);
    chk("stall1_instr", a_Instr, data);
    chk("stall1_valid", {31'h0, a_InstrValid}, 32'h1);
    PCSrc = 2'b01; Imm16 = 16'h0010;
    step();
    chk("stall2_pc", a_PC, 32'h0000_2000);
    chk("stall2_instr", a_Instr, data);
    ImemReady = 1'b0;
    Stall = 1'b0; PCSrc = 2'b00;
    exp_retire++;
    step();
    $display("stall: addr=2000 next_pc=%h (required 00002004)", a_PC);
    chk("stall_exit_pc", a_PC, 32'h0000_2004);
    chk("stall_exit_req", {31'h0, a_ImemReq}, 32'h1);
    chk_counters("stall");
    addr_q.push_back(32'h0000_2004);

    // Misaligned jr: trap on the main instance, realign on the other.
    chk("mis_fetch_addr", a_ImemAddr, addr_q.pop_front());
    ImemReady = 1'b1; ImemData = $urandom;
    step();
    ImemReady = 1'b0;
    PCSrc = 2'b11; RsVal = 32'h0000_2002;
    step();
    $display("misaligned jr: err=%0d pc=%h realign_pc=%h", a_Err, a_PC, b_PC);
    chk("mis_err", {31'h0, a_Err}, 32'h1);
    chk("mis_pc_hold", a_PC, 32'h0000_2004);
    chk("mis_req", {31'h0, a_ImemReq}, 32'h0);
    chk("mis_valid", {31'h0, a_InstrValid}, 32'h0);
    chk("nomis_pc", b_PC, 32'h0000_2000);
    chk("nomis_err", {31'h0, b_Err}, 32'h0);
    chk("nomis_req", {31'h0, b_ImemReq}, 32'h1);
    ImemReady = 1'b1; PCSrc = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("trap_req", {31'h0, a_ImemReq}, 32'h0);
      chk("trap_err", {31'h0, a_Err}, 32'h1);
    end
    chk_counters("trap");

    // Reset while trapped.
    ImemReady = 1'b0;
    rst = 1'b1;
    #1;
    chk("trap_rst_req", {31'h0, a_ImemReq}, 32'h0);
    step();
    rst = 1'b0;
    exp_retire = 0; exp_taken = 0;
    #1;
    $display("reset from trap: pc=%h err=%0d req=%0d", a_PC, a_Err, a_ImemReq);
    chk("trap_rst_pc", a_PC, 32'h0);
    chk("trap_rst_err", {31'h0, a_Err}, 32'h0);
    chk("trap_rst_req_hi", {31'h0, a_ImemReq}, 32'h1);
    chk_counters("trap_rst");
    addr_q.delete();
    instr_q.delete();
    addr_q.push_back(32'h0);
    do_instr(100, vecs[0]);

    // Reset in the middle of a fetch (ImemReady arrives with rst; rst wins).
    step();
    chk("midfetch_addr", a_ImemAddr, 32'h0000_0004);
    rst = 1'b1; ImemReady = 1'b1; ImemData = 32'hDEAD_BEEF;
    #1;
    chk("midfetch_rst_req", {31'h0, a_ImemReq}, 32'h0);
    step();
    rst = 1'b0; ImemReady = 1'b0;
    exp_retire = 0; exp_taken = 0;
    #1;
    $display("reset mid-fetch: pc=%h instr=%h valid=%0d", a_PC, a_Instr, a_InstrValid);
    chk("midfetch_pc", a_PC, 32'h0);
    chk("midfetch_instr", a_Instr, 32'h0);
    chk("midfetch_valid", {31'h0, a_InstrValid}, 32'h0);
    chk_counters("midfetch");
    addr_q.delete();
    addr_q.push_back(32'h0);
    v = vecs[0];
    do_instr(101, v);
    chk_counters("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
